// File: rtl/ace_tape_loader.sv
// ace_tape_loader
//   Expands a .ACE snapshot byte stream from the HPS download channel into
//   RAM writes for the ace core. Literal bytes are written straight through;
//   the escape sequence ED n v writes byte v n times, and ED 00 marks the
//   end of the stream and holds the channel for HOLD_CYCLES cycles.
//
//   Handshake: in_wr is a one-cycle byte strobe. It is accepted only when
//   in_wait is low and the loader is not idle; strobes while in_wait is high
//   or in IDLE are dropped with no state change. in_wait is registered, so
//   the source sees back-pressure from the cycle after the byte that
//   caused it.
//
//   Optional feature: define ACE_LOADER_CSUM_EN to add the csum output
//   (XOR of all bytes written since the last download start).
//
//   dbg_state exposes the FSM state encoding for observation.
module ace_tape_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          HOLD_CYCLES = 3000000,
  parameter int          HOLD_W      = 22
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        in_wr,
  input  logic [7:0]  in_data,
  output logic        in_wait,
  output logic        core_reset,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        done,
  output logic [2:0]  dbg_state
`ifdef ACE_LOADER_CSUM_EN
  ,
  output logic [7:0]  csum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LIT  = 3'd1,
    S_ESC  = 3'd2,
    S_VAL  = 3'd3,
    S_RUN  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [7:0]        ESC_BYTE  = 8'hED;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic              dl_q;
  logic              core_reset_q, core_reset_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              in_wait_q, in_wait_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef ACE_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic dl_rise;
  logic dl_fall;
  logic accept;

  assign dl_rise = dl_active & ~dl_q;
  assign dl_fall = ~dl_active & dl_q;
  assign accept  = in_wr & ~in_wait_q & (state_q != S_IDLE);

  // Next-state and output decode; download edges override the stream decoder.
  always_comb begin
    state_d      = state_q;
    core_reset_d = 1'b0;
    mem_en_d     = mem_en_q;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_wr_q ? (mem_addr_q + 16'd1) : mem_addr_q;
    mem_data_d   = mem_data_q;
    in_wait_d    = in_wait_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
`ifdef ACE_LOADER_CSUM_EN
    csum_d       = mem_wr_q ? (csum_q ^ mem_data_q) : csum_q;
`endif

    if (dl_rise) begin
      core_reset_d = 1'b1;
      mem_addr_d   = BASE_ADDR;
      done_d       = 1'b0;
      in_wait_d    = 1'b0;
      cnt_d        = 8'd0;
      hold_d       = '0;
      state_d      = S_LIT;
`ifdef ACE_LOADER_CSUM_EN
      csum_d       = 8'd0;
`endif
    end else if (dl_fall) begin
      // Any partially decoded escape or run is abandoned here.
      mem_en_d  = 1'b0;
      in_wait_d = 1'b0;
      cnt_d     = 8'd0;
      hold_d    = '0;
      state_d   = S_IDLE;
    end else begin
      if (accept) begin
        mem_en_d = 1'b1;
      end
      case (state_q)
        S_LIT: begin
          if (accept) begin
            if (in_data == ESC_BYTE) begin
              state_d = S_ESC;
            end else begin
              mem_wr_d   = 1'b1;
              mem_data_d = in_data;
            end
          end
        end
        S_ESC: begin
          if (accept) begin
            if (in_data == 8'd0) begin
              in_wait_d = 1'b1;
              hold_d    = '0;
              state_d   = S_HOLD;
            end else begin
              cnt_d   = in_data;
              state_d = S_VAL;
            end
          end
        end
        S_VAL: begin
          // First run write is issued here; cnt then holds the writes left.
          if (accept) begin
            mem_data_d = in_data;
            mem_wr_d   = 1'b1;
            in_wait_d  = 1'b1;
            cnt_d      = cnt_q - 8'd1;
            state_d    = S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q != 8'd0) begin
            mem_wr_d = 1'b1;
            cnt_d    = cnt_q - 8'd1;
          end else begin
            in_wait_d = 1'b0;
            state_d   = S_LIT;
          end
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            in_wait_d = 1'b0;
            done_d    = 1'b1;
            hold_d    = '0;
            state_d   = S_IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      core_reset_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_data_q   <= 8'd0;
      in_wait_q    <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= 8'd0;
      hold_q       <= '0;
`ifdef ACE_LOADER_CSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_active;
      core_reset_q <= core_reset_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      in_wait_q    <= in_wait_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
`ifdef ACE_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_wait    = in_wait_q;
  assign core_reset = core_reset_q;
  assign mem_en     = mem_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign done       = done_q;
  assign dbg_state  = state_q;
`ifdef ACE_LOADER_CSUM_EN
  assign csum       = csum_q;
`endif

endmodule

// File: tb/tb_ace_tape_loader.sv
// Bench for ace_tape_loader: two instances share stimulus, one at the
// default base address and one at FFFE to exercise address wrap.
module tb_ace_tape_loader;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        dl_active;
  logic        in_wr;
  logic [7:0]  in_data;

  logic        in_wait, core_reset, mem_en, mem_wr, done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [2:0]  dbg_state;

  logic        u2_in_wait, u2_core_reset, u2_mem_en, u2_mem_wr, u2_done;
  logic [15:0] u2_mem_addr;
  logic [7:0]  u2_mem_data;
  logic [2:0]  u2_dbg_state;
`ifdef ACE_LOADER_CSUM_EN
  logic [7:0]  csum, u2_csum;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ace_tape_loader #(.BASE_ADDR(16'h2000), .HOLD_CYCLES(10), .HOLD_W(22)) u_dut (
    .clk_sys(clk), .reset(reset), .dl_active(dl_active), .in_wr(in_wr), .in_data(in_data),
    .in_wait(in_wait), .core_reset(core_reset), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .done(done), .dbg_state(dbg_state)
`ifdef ACE_LOADER_CSUM_EN
    , .csum(csum)
`endif
  );

  ace_tape_loader #(.BASE_ADDR(16'hFFFE), .HOLD_CYCLES(10), .HOLD_W(22)) u_dut2 (
    .clk_sys(clk), .reset(reset), .dl_active(dl_active), .in_wr(in_wr), .in_data(in_data),
    .in_wait(u2_in_wait), .core_reset(u2_core_reset), .mem_en(u2_mem_en), .mem_wr(u2_mem_wr),
    .mem_addr(u2_mem_addr), .mem_data(u2_mem_data), .done(u2_done), .dbg_state(u2_dbg_state)
`ifdef ACE_LOADER_CSUM_EN
    , .csum(u2_csum)
`endif
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp2_q[$];
  logic        chk2 = 1'b0;
  logic [15:0] exp_addr;
  logic [15:0] exp2_addr;
  logic [7:0]  exp_csum;

  // Monitor every RAM write of the main instance against the expected queue.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got [%h]=%h, no write expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL write: got [%h]=%h, expected [%h]=%h", mem_addr, mem_data, e[23:8], e[7:0]);
        end
      end
    end
  end

  // Monitor the wrap instance only while the wrap scenario is active.
  always @(negedge clk) begin
    if (chk2 && u2_mem_wr === 1'b1) begin
      logic [23:0] e;
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write2: got [%h]=%h", u2_mem_addr, u2_mem_data);
      end else begin
        e = exp2_q.pop_front();
        if ({u2_mem_addr, u2_mem_data} !== e) begin
          errors++;
          $display("FAIL write2: got [%h]=%h, expected [%h]=%h", u2_mem_addr, u2_mem_data, e[23:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write for the main instance (and wrap instance when enabled).
  task automatic push_write(input logic [7:0] d);
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 16'd1;
    exp_csum = exp_csum ^ d;
    if (chk2) begin
      exp2_q.push_back({exp2_addr, d});
      exp2_addr = exp2_addr + 16'd1;
    end
  endtask

  // Strobe one byte once in_wait is low; the DUT captures it on the
  // posedge just before this task returns.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (in_wait === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: in_wait=%b after %0d cycles, required 0", in_wait, n);
    end
    in_wr   = 1'b1;
    in_data = b;
    tick();
    in_wr   = 1'b0;
    in_data = 8'h00;
  endtask

  task automatic start_download();
    dl_active = 1'b0;
    tick();
    tick();
    dl_active = 1'b1;
    tick();
    exp_addr  = 16'h2000;
    exp2_addr = 16'hFFFE;
    exp_csum  = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    dl_active = 1'b0;
    in_wr = 1'b0;
    in_data = 8'h00;
    repeat (3) tick();
    checks++;
    if ({in_wait, core_reset, mem_en, mem_wr, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000", {in_wait, core_reset, mem_en, mem_wr, done});
    end
    checks++;
    if (mem_addr !== 16'h2000) begin
      errors++;
      $display("FAIL reset_addr: got %h, expected 2000", mem_addr);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected 0", dbg_state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start();
    dl_active = 1'b1;
    tick();
    exp_addr = 16'h2000;
    exp2_addr = 16'hFFFE;
    exp_csum = 8'h00;
    checks++;
    if (core_reset !== 1'b1 || mem_addr !== 16'h2000 || in_wait !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start: got core_reset=%b addr=%h wait=%b done=%b, expected 1 2000 0 0",
               core_reset, mem_addr, in_wait, done);
    end
    tick();
    checks++;
    if (core_reset !== 1'b0 || dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL start_pulse: got core_reset=%b state=%0d, expected 0 1", core_reset, dbg_state);
    end
  endtask

  task automatic test_literal();
    logic [7:0] lits [2];
    lits[0] = 8'h41;
    lits[1] = 8'h42;
    for (int i = 0; i < 2; i++) begin
      logic [15:0] a;
      a = exp_addr;
      push_write(lits[i]);
      send_byte(lits[i]);
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== a || mem_data !== lits[i]) begin
        errors++;
        $display("FAIL literal_latency: got wr=%b [%h]=%h, expected 1 [%h]=%h",
                 mem_wr, mem_addr, mem_data, a, lits[i]);
      end
    end
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL mem_en: got %b, expected 1", mem_en);
    end
  endtask

  task automatic test_run();
    send_byte(8'hED);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) push_write(8'h55);
    send_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_wr !== 1'b1 || in_wait !== 1'b1 || mem_addr !== 16'(16'h2002 + i)) begin
        errors++;
        $display("FAIL run_cycle%0d: got wr=%b wait=%b addr=%h, expected 1 1 %h",
                 i, mem_wr, in_wait, mem_addr, 16'(16'h2002 + i));
      end
      tick();
    end
    checks++;
    if (mem_wr !== 1'b0 || in_wait !== 1'b0) begin
      errors++;
      $display("FAIL run_end: got wr=%b wait=%b, expected 0 0", mem_wr, in_wait);
    end
`ifdef ACE_LOADER_CSUM_EN
    checks++;
    if (csum !== exp_csum || csum !== 8'h56) begin
      errors++;
      $display("FAIL csum: got %h, expected %h", csum, exp_csum);
    end
`endif
    push_write(8'h66);
    send_byte(8'h66);
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h2005) begin
      errors++;
      $display("FAIL run_next_literal: got wr=%b addr=%h, expected 1 2005", mem_wr, mem_addr);
    end
  endtask

  task automatic test_end_marker();
    int n;
    send_byte(8'hED);
    send_byte(8'h00);
    n = 0;
    while (in_wait === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL hold_len: got %0d cycles, expected 10", n);
    end
    checks++;
    if (done !== 1'b1 || in_wait !== 1'b0) begin
      errors++;
      $display("FAIL done: got done=%b wait=%b, expected 1 0", done, in_wait);
    end
    send_byte(8'h77);
    tick();
    checks++;
    if (mem_wr !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL stray_byte: got wr=%b state=%0d, expected 0 0", mem_wr, dbg_state);
    end
  endtask

  task automatic test_wrap();
    chk2 = 1'b1;
    start_download();
    send_byte(8'h01);
    push_write(8'h01);
    send_byte(8'h02);
    push_write(8'h02);
    send_byte(8'h03);
    push_write(8'h03);
    tick();
    tick();
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_pending: got %0d writes outstanding, expected 0", exp2_q.size());
    end
    chk2 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start_download();
    send_byte(8'hED);
    send_byte(8'h05);
    push_write(8'hAA);
    push_write(8'hAA);
    send_byte(8'hAA);
    tick();
    reset = 1'b1;
    dl_active = 1'b0;
    tick();
    checks++;
    if (mem_wr !== 1'b0 || in_wait !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got wr=%b wait=%b state=%0d, expected 0 0 0",
               mem_wr, in_wait, dbg_state);
    end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  // Back-to-back literals with random data, including ED-free values only.
  task automatic test_back_to_back();
    start_download();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 8'hEC));
      push_write(b);
      send_byte(b);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_literal();
    test_run();
    test_end_marker();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
